// File: rtl/dual_port_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : dual_port_reg_file
// Description : 32 x 8-bit general-purpose register file with two independent
//               access ports (Rd, Rr). Each port has its own chip-select,
//               write-enable and output-enable, plus a bidirectional data bus.
//               Writes land on the rising clock edge. Reads are combinational
//               and reach the bus only when the port is selected, reading and
//               output-enabled.
//
// Ports       : clk                   system clock, rising-edge active
//               reset                 synchronous, active-high; clears storage
//               rd_addr / rr_addr     port register addresses
//               rd_data / rr_data     bidirectional data buses
//                                     (write data in, read data out)
//               rd_cs / rr_cs         port select; port ignored when low
//               rd_we / rr_we         1 = write, 0 = read
//               rd_oe / rr_oe         read output enable
//               collision             sticky same-address dual-write flag
//                                     (present only when the macro below is
//                                     defined)
//
// Option      : DUAL_PORT_REG_FILE_COLLISION_CHECK_EN
//               When defined, adds the collision output and its register.
//
// Revision    : 1.0 - initial release
// ============================================================================
module dual_port_reg_file #(
    parameter int DATA_WIDTH   = 8,
    parameter int R_ADDR_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [R_ADDR_WIDTH-1:0] rd_addr,
    input  logic [R_ADDR_WIDTH-1:0] rr_addr,
    inout  wire  [DATA_WIDTH-1:0]   rd_data,
    inout  wire  [DATA_WIDTH-1:0]   rr_data,
    input  logic                    rd_cs,
    input  logic                    rr_cs,
    input  logic                    rd_we,
    input  logic                    rr_we,
    input  logic                    rd_oe,
    input  logic                    rr_oe
`ifdef DUAL_PORT_REG_FILE_COLLISION_CHECK_EN
    ,
    output logic                    collision
`endif
);

    localparam int c_DEPTH = 2 ** R_ADDR_WIDTH;

    // Plain storage; r26..r31 (X/Y/Z pointer pairs) get no special treatment.
    logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];

    // ------------------------------------------------------------------------
    // Port decode. Every term is ANDed with cs first, so an X on addr/we/oe
    // while the port is deselected cannot reach the write or drive enables.
    // ------------------------------------------------------------------------
    logic w_rd_write;
    logic w_rr_write;
    logic w_rd_read;
    logic w_rr_read;

    assign w_rd_write = rd_cs & rd_we;
    assign w_rr_write = rr_cs & rr_we;
    // Buses stay released while reset is held so nothing fights a cleared file.
    assign w_rd_read  = rd_cs & ~rd_we & rd_oe & ~reset;
    assign w_rr_read  = rr_cs & ~rr_we & rr_oe & ~reset;

    // ------------------------------------------------------------------------
    // Read path: combinational, pre-edge contents. A read of an address the
    // other port is writing returns the old value until the edge.
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_rd_rdata;
    logic [DATA_WIDTH-1:0] w_rr_rdata;

    assign w_rd_rdata = r_mem[rd_addr];
    assign w_rr_rdata = r_mem[rr_addr];

    // A port never drives while writing: w_*_read already excludes we=1.
    assign rd_data = w_rd_read ? w_rd_rdata : {DATA_WIDTH{1'bz}};
    assign rr_data = w_rr_read ? w_rr_rdata : {DATA_WIDTH{1'bz}};

    // ------------------------------------------------------------------------
    // Write path. Reset wins over any write requested in the same cycle.
    // The Rd write is issued after the Rr write so that, when both target the
    // same address, the later non-blocking assignment (Rd) is the one kept.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_rr_write) begin
                r_mem[rr_addr] <= rr_data;
            end
            if (w_rd_write) begin
                r_mem[rd_addr] <= rd_data;
            end
        end
    end

`ifdef DUAL_PORT_REG_FILE_COLLISION_CHECK_EN
    // ------------------------------------------------------------------------
    // Sticky collision flag: set on any edge where both ports write the same
    // register; only reset clears it.
    // ------------------------------------------------------------------------
    logic r_collision;
    logic w_same_addr_write;

    assign w_same_addr_write = w_rd_write & w_rr_write & (rd_addr == rr_addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_collision <= 1'b0;
        end else if (w_same_addr_write) begin
            r_collision <= 1'b1;
        end
    end

    assign collision = r_collision;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dual_port_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_port_reg_file
// Description : Self-checking bench for dual_port_reg_file. A driver issues
//               one access per port per cycle and pushes the expected bus
//               values into a queue; a monitor compares them on the falling
//               edge. Released buses are pulled up, so an undriven bus reads
//               all ones.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_port_reg_file;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int c_OP_IDLE  = 0;
    localparam int c_OP_WRITE = 1;
    localparam int c_OP_READ  = 2;
    localparam int c_OP_NOOE  = 3;
    localparam logic [DW-1:0] c_RELEASED = 8'hFF;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rd_addr, rr_addr;
    logic          rd_cs, rr_cs, rd_we, rr_we, rd_oe, rr_oe;
    logic [DW-1:0] rd_drv, rr_drv;
    logic          rd_drv_en, rr_drv_en;
    wire  [DW-1:0] rd_data;
    wire  [DW-1:0] rr_data;

    assign rd_data = rd_drv_en ? rd_drv : {DW{1'bz}};
    assign rr_data = rr_drv_en ? rr_drv : {DW{1'bz}};
    pullup pu_rd[DW-1:0] (rd_data);
    pullup pu_rr[DW-1:0] (rr_data);

`ifdef DUAL_PORT_REG_FILE_COLLISION_CHECK_EN
    logic collision;
`endif

    dual_port_reg_file #(.DATA_WIDTH(DW), .R_ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .rd_addr (rd_addr),
        .rr_addr (rr_addr),
        .rd_data (rd_data),
        .rr_data (rr_data),
        .rd_cs   (rd_cs),
        .rr_cs   (rr_cs),
        .rd_we   (rd_we),
        .rr_we   (rr_we),
        .rd_oe   (rd_oe),
        .rr_oe   (rr_oe)
`ifdef DUAL_PORT_REG_FILE_COLLISION_CHECK_EN
        ,
        .collision (collision)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard entry: kind 0 = Rd bus, 1 = Rr bus, 2 = collision flag.
    typedef struct {
        int            cyc;
        int            kind;
        logic [DW-1:0] exp;
    } exp_t;

    exp_t          sb_q[$];
    int            cyc       = 0;
    int            checks    = 0;
    int            errors    = 0;
    bit            done      = 1'b0;

    // Reference model: plain array of register contents plus sticky flag.
    logic [DW-1:0] model_mem [0:31];
    bit            model_coll  = 1'b0;
    bit            model_known = 1'b0;

    task automatic drive_port(input int op, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd,
                              output logic cs, output logic we, output logic oe,
                              output logic [AW-1:0] addr,
                              output logic [DW-1:0] drv, output logic drv_en);
        drv    = wd;
        drv_en = (op == c_OP_WRITE);
        case (op)
            c_OP_WRITE: begin cs = 1'b1; we = 1'b1;  oe = 1'bx; addr = a; end
            c_OP_READ:  begin cs = 1'b1; we = 1'b0;  oe = 1'b1; addr = a; end
            c_OP_NOOE:  begin cs = 1'b1; we = 1'b0;  oe = 1'b0; addr = a; end
            default:    begin cs = 1'b0; we = 1'bx;  oe = 1'bx; addr = 'x; end
        endcase
    endtask

    // One cycle of stimulus: set inputs just after the rising edge, record
    // what the buses must show before the next edge, then apply the cycle's
    // effect to the model for the following cycle.
    task automatic step(input bit rst, input int rdop, input int ra, input int rdw,
                        input int rrop, input int rb, input int rrw);
        logic [AW-1:0] a_rd, a_rr;
        logic [DW-1:0] v_rd, v_rr;
        exp_t          e;
        a_rd = AW'(ra);
        a_rr = AW'(rb);
        v_rd = DW'(rdw);
        v_rr = DW'(rrw);
        @(posedge clk);
        #1;
        cyc++;
        reset = rst;
        drive_port(rdop, a_rd, v_rd, rd_cs, rd_we, rd_oe, rd_addr, rd_drv, rd_drv_en);
        drive_port(rrop, a_rr, v_rr, rr_cs, rr_we, rr_oe, rr_addr, rr_drv, rr_drv_en);

        e.cyc  = cyc;
        e.kind = 0;
        e.exp  = (!rst && rdop == c_OP_READ) ? model_mem[a_rd] : c_RELEASED;
        if (rdop != c_OP_WRITE && (rst || model_known)) sb_q.push_back(e);
        e.kind = 1;
        e.exp  = (!rst && rrop == c_OP_READ) ? model_mem[a_rr] : c_RELEASED;
        if (rrop != c_OP_WRITE && (rst || model_known)) sb_q.push_back(e);
`ifdef DUAL_PORT_REG_FILE_COLLISION_CHECK_EN
        e.kind = 2;
        e.exp  = DW'(model_coll);
        if (model_known) sb_q.push_back(e);
`endif

        if (rst) begin
            for (int i = 0; i < 32; i++) model_mem[i] = '0;
            model_coll  = 1'b0;
            model_known = 1'b1;
        end else begin
            if (rrop == c_OP_WRITE) model_mem[a_rr] = v_rr;
            if (rdop == c_OP_WRITE) model_mem[a_rd] = v_rd;
            if (rdop == c_OP_WRITE && rrop == c_OP_WRITE && a_rd == a_rr)
                model_coll = 1'b1;
        end
    endtask

    // Monitor: consume every expectation belonging to the current cycle.
    initial begin
        exp_t          e;
        logic [DW-1:0] act;
        string         nm;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                e = sb_q.pop_front();
                case (e.kind)
                    0: begin act = rd_data; nm = "rd_data"; end
                    1: begin act = rr_data; nm = "rr_data"; end
`ifdef DUAL_PORT_REG_FILE_COLLISION_CHECK_EN
                    2: begin act = DW'(collision); nm = "collision"; end
`endif
                    default: begin act = 'x; nm = "unknown"; end
                endcase
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s cycle %0d: got %h expected %h", nm, e.cyc, act, e.exp);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        rd_cs = 1'b0; rr_cs = 1'b0; rd_we = 1'b0; rr_we = 1'b0;
        rd_oe = 1'b0; rr_oe = 1'b0; rd_addr = '0; rr_addr = '0;
        rd_drv = '0; rr_drv = '0; rd_drv_en = 1'b0; rr_drv_en = 1'b0;
        for (int i = 0; i < 32; i++) model_mem[i] = '0;

        // Reset, then read every register through Rd; Rr stays released.
        step(1, c_OP_IDLE, 0, 0, c_OP_IDLE, 0, 0);
        for (int i = 0; i < 32; i++) step(0, c_OP_READ, i, 0, c_OP_IDLE, 0, 0);

        // Write r5 via Rd, read it back via Rr with and without output enable.
        step(0, c_OP_WRITE, 5, 8'hA5, c_OP_IDLE, 0, 0);
        step(0, c_OP_IDLE, 0, 0, c_OP_READ, 5, 0);
        step(0, c_OP_IDLE, 0, 0, c_OP_NOOE, 5, 0);

        // Dual write of the X pointer pair, then dual read.
        step(0, c_OP_WRITE, 26, 8'h34, c_OP_WRITE, 27, 8'h12);
        step(0, c_OP_READ, 26, 0, c_OP_READ, 27, 0);

        // Same-address dual write: Rd value kept, collision becomes sticky.
        step(0, c_OP_WRITE, 10, 8'h11, c_OP_WRITE, 10, 8'h22);
        step(0, c_OP_READ, 10, 0, c_OP_READ, 10, 0);
        step(0, c_OP_IDLE, 0, 0, c_OP_IDLE, 0, 0);

        // Read-during-write from the other port.
        step(0, c_OP_WRITE, 3, 8'h01, c_OP_IDLE, 0, 0);
        step(0, c_OP_WRITE, 3, 8'hFF, c_OP_READ, 3, 0);
        step(0, c_OP_IDLE, 0, 0, c_OP_READ, 3, 0);

        // Reset coinciding with a write drops the write and clears r7.
        step(0, c_OP_WRITE, 7, 8'h77, c_OP_IDLE, 0, 0);
        step(1, c_OP_WRITE, 7, 8'h55, c_OP_READ, 7, 0);
        step(0, c_OP_READ, 7, 0, c_OP_READ, 10, 0);

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 59) == 0),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), int'($urandom_range(0, 255)));
        end

        step(0, c_OP_IDLE, 0, 0, c_OP_IDLE, 0, 0);
        @(posedge clk);
        @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout: got no completion expected completion");
            $fatal(1, "timeout");
        end
    end

endmodule
`default_nettype wire
